fifo_wr_arb: RTL and testbench

//  Round-robin arbiter sharing the write port of the async FIFO between two

---
 rtl/fifo_wr_arb.sv | 161 ++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// fifo_wr_arb
//
// Round-robin arbiter that shares the write port of the async FIFO between
// two producers in the clk_50m domain. A producer keeps the port for a burst
// of up to BURST_LEN words, or until it stops requesting. Words are accepted
// only while the FIFO has room below FULL_THR, and are then presented to the
// FIFO through a one-stage registered write pipeline.
//
// Parameters
//   DW        data width, matches the FIFO data port
//   AW        width of wr_usedw
//   BURST_LEN maximum words per grant, 1..255
//   FULL_THR  stop accepting words once wr_usedw reaches this level
//
// Ports
//   clk       write-side clock (clk_50m)
//   rst_n     asynchronous reset, active low
//   req0/1    producer has a word on dataN; held stable until ackN
//   data0/1   producer data
//   ack0/1    dataN consumed this cycle (combinational)
//   gnt0/1    producer owns the write port (decoded from state)
//   wr_full   FIFO write-side full flag
//   wr_usedw  FIFO write-side used word count
//   wr_req    FIFO write request, registered
//   wr_data   FIFO write data, registered
// ----------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int BURST_LEN = 16,
    parameter int FULL_THR  = 252
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    output logic          gnt1,
    input  logic          wr_full,
    input  logic [AW-1:0] wr_usedw,
    output logic          wr_req,
    output logic [DW-1:0] wr_data
);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_t;

    localparam logic [7:0]    LAST_CNT = 8'(BURST_LEN - 1);
    localparam logic [AW-1:0] THR      = AW'(FULL_THR);

    state_t     state;
    state_t     state_next;
    logic       last;
    logic [7:0] burst_cnt;
    logic       space_ok;
    logic       new_grant;

    // Grants decode straight from the state register, so they can never
    // both be high and they drop immediately when reset is asserted.
    assign gnt0     = (state == GNT0);
    assign gnt1     = (state == GNT1);
    assign space_ok = !wr_full && (wr_usedw < THR);
    assign ack0     = gnt0 && req0 && space_ok;
    assign ack1     = gnt1 && req1 && space_ok;

    // Next-state logic. new_grant marks every cycle that opens a fresh burst,
    // including a re-grant to the same producer, so the count restarts and
    // the round-robin pointer is updated in one place.
    // A burst ends on its last acked word or when its owner stops requesting.
    // A blocked owner (no space) keeps requesting, so it stays granted.
    always_comb begin
        state_next = state;
        new_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_next = last ? GNT0 : GNT1;
                    new_grant  = 1'b1;
                end else if (req0) begin
                    state_next = GNT0;
                    new_grant  = 1'b1;
                end else if (req1) begin
                    state_next = GNT1;
                    new_grant  = 1'b1;
                end
            end
            GNT0: begin
                if ((ack0 && (burst_cnt == LAST_CNT)) || !req0) begin
                    if (req1) begin
                        state_next = GNT1;
                        new_grant  = 1'b1;
                    end else if (req0) begin
                        state_next = GNT0;
                        new_grant  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GNT1: begin
                if ((ack1 && (burst_cnt == LAST_CNT)) || !req1) begin
                    if (req0) begin
                        state_next = GNT0;
                        new_grant  = 1'b1;
                    end else if (req1) begin
                        state_next = GNT1;
                        new_grant  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, burst counter and round-robin pointer. last=1 out of reset so
    // producer 0 wins the first contention. A new grant takes priority over
    // the ack increment because the ack that closes a burst must not leak
    // into the count of the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (new_grant) begin
                burst_cnt <= 8'd0;
                last      <= (state_next == GNT1);
            end else if (ack0 || ack1) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
        end
    end

    // One-stage write pipeline: each acked word reaches the FIFO exactly one
    // cycle later. wr_data keeps its last value when nothing is acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_req  <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_req <= ack0 || ack1;
            if (ack0) begin
                wr_data <= data0;
            end else if (ack1) begin
                wr_data <= data1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arb
//
// Testbench for fifo_wr_arb with BURST_LEN=4. A table of per-cycle records
// (inputs and expected outputs) covers single-producer bursts with regrant,
// alternation between both producers, threshold and full throttling, an
// early request drop and IDLE contention. Hand-written sequences cover reset
// hold/release and an asynchronous reset pulse in the middle of a grant.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arb;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       gnt0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       gnt1;
    logic       wr_full;
    logic [7:0] wr_usedw;
    logic       wr_req;
    logic [7:0] wr_data;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       r0;
        logic [7:0] d0;
        logic       r1;
        logic [7:0] d1;
        logic       full;
        logic [7:0] usedw;
        logic       a0;
        logic       a1;
        logic       g0;
        logic       g1;
        logic       wreq;
        logic [7:0] wdata;
    } vec_t;

    vec_t vecs[$];

    fifo_wr_arb #(
        .DW(8),
        .AW(8),
        .BURST_LEN(4),
        .FULL_THR(252)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0(req0),
        .data0(data0),
        .ack0(ack0),
        .gnt0(gnt0),
        .req1(req1),
        .data1(data1),
        .ack1(ack1),
        .gnt1(gnt1),
        .wr_full(wr_full),
        .wr_usedw(wr_usedw),
        .wr_req(wr_req),
        .wr_data(wr_data)
    );

    // Free-running 100 MHz-style clock; posedges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1,
                                 input logic full, input logic [7:0] usedw);
        req0     = r0;
        data0    = d0;
        req1     = r1;
        data1    = d1;
        wr_full  = full;
        wr_usedw = usedw;
    endtask

    task automatic addVec(input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1,
                          input logic full, input logic [7:0] usedw,
                          input logic a0, input logic a1, input logic g0, input logic g1,
                          input logic wreq, input logic [7:0] wdata);
        vec_t v;
        v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.full = full; v.usedw = usedw;
        v.a0 = a0; v.a1 = a1; v.g0 = g0; v.g1 = g1; v.wreq = wreq; v.wdata = wdata;
        vecs.push_back(v);
    endtask

    initial begin
        // One record per clock cycle: inputs driven after the falling edge,
        // outputs sampled 1 ns later. Registered outputs reflect the acks of
        // the previous cycle.
        //     r0  d0     r1  d1     full usedw   a0 a1 g0 g1 wrq wdata
        // single producer, burst of 4 then regrant with no gap
        addVec(1, 8'h01, 0, 8'h00, 0, 8'd0,   0, 0, 0, 0, 0, 8'h00);
        addVec(1, 8'h01, 0, 8'h00, 0, 8'd0,   1, 0, 1, 0, 0, 8'h00);
        addVec(1, 8'h02, 0, 8'h00, 0, 8'd0,   1, 0, 1, 0, 1, 8'h01);
        addVec(1, 8'h03, 0, 8'h00, 0, 8'd0,   1, 0, 1, 0, 1, 8'h02);
        addVec(1, 8'h04, 0, 8'h00, 0, 8'd0,   1, 0, 1, 0, 1, 8'h03);
        addVec(1, 8'h05, 0, 8'h00, 0, 8'd0,   1, 0, 1, 0, 1, 8'h04);
        addVec(1, 8'h06, 0, 8'h00, 0, 8'd0,   1, 0, 1, 0, 1, 8'h05);
        // both requesting: finish producer 0 burst, then 4 to producer 1
        addVec(1, 8'h07, 1, 8'h81, 0, 8'd0,   1, 0, 1, 0, 1, 8'h06);
        addVec(1, 8'h08, 1, 8'h81, 0, 8'd0,   1, 0, 1, 0, 1, 8'h07);
        addVec(1, 8'h09, 1, 8'h81, 0, 8'd0,   0, 1, 0, 1, 1, 8'h08);
        addVec(1, 8'h09, 1, 8'h82, 0, 8'd0,   0, 1, 0, 1, 1, 8'h81);
        addVec(1, 8'h09, 1, 8'h83, 0, 8'd0,   0, 1, 0, 1, 1, 8'h82);
        addVec(1, 8'h09, 1, 8'h84, 0, 8'd0,   0, 1, 0, 1, 1, 8'h83);
        addVec(1, 8'h09, 1, 8'h85, 0, 8'd0,   1, 0, 1, 0, 1, 8'h84);
        addVec(1, 8'h0A, 1, 8'h85, 0, 8'd0,   1, 0, 1, 0, 1, 8'h09);
        // occupancy hits the threshold mid-burst, then falls back below it
        addVec(1, 8'h0B, 1, 8'h85, 0, 8'd252, 0, 0, 1, 0, 1, 8'h0A);
        addVec(1, 8'h0B, 1, 8'h85, 0, 8'd251, 1, 0, 1, 0, 0, 8'h0A);
        addVec(1, 8'h0C, 1, 8'h85, 0, 8'd0,   1, 0, 1, 0, 1, 8'h0B);
        // producer 1 burst with a wr_full stall in the middle
        addVec(1, 8'h0D, 1, 8'h85, 0, 8'd0,   0, 1, 0, 1, 1, 8'h0C);
        addVec(1, 8'h0D, 1, 8'h86, 1, 8'd0,   0, 0, 0, 1, 1, 8'h85);
        addVec(1, 8'h0D, 1, 8'h86, 0, 8'd0,   0, 1, 0, 1, 0, 8'h85);
        addVec(1, 8'h0D, 1, 8'h87, 0, 8'd0,   0, 1, 0, 1, 1, 8'h86);
        addVec(1, 8'h0D, 1, 8'h88, 0, 8'd0,   0, 1, 0, 1, 1, 8'h87);
        // producer 0 drops its request after 2 words
        addVec(1, 8'h0D, 1, 8'h89, 0, 8'd0,   1, 0, 1, 0, 1, 8'h88);
        addVec(1, 8'h0E, 1, 8'h89, 0, 8'd0,   1, 0, 1, 0, 1, 8'h0D);
        addVec(0, 8'h00, 1, 8'h89, 0, 8'd0,   0, 0, 1, 0, 1, 8'h0E);
        addVec(0, 8'h00, 1, 8'h89, 0, 8'd0,   0, 1, 0, 1, 0, 8'h0E);
        // back to IDLE, then contention goes to producer 0 (last was 1)
        addVec(0, 8'h00, 0, 8'h00, 0, 8'd0,   0, 0, 0, 1, 1, 8'h89);
        addVec(1, 8'h0F, 1, 8'h8A, 0, 8'd0,   0, 0, 0, 0, 0, 8'h89);
        addVec(1, 8'h0F, 1, 8'h8A, 0, 8'd0,   1, 0, 1, 0, 0, 8'h89);
        addVec(1, 8'h10, 1, 8'h8A, 0, 8'd0,   1, 0, 1, 0, 1, 8'h0F);

        // Reset held with both producers requesting.
        rst_n = 1'b0;
        applyStimulus(1, 8'h55, 1, 8'hAA, 0, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_wr_req", {7'd0, wr_req}, 8'd0);
        checkOutput("reset_wr_data", wr_data, 8'h00);
        checkOutput("reset_ack0", {7'd0, ack0}, 8'd0);
        checkOutput("reset_ack1", {7'd0, ack1}, 8'd0);
        checkOutput("reset_gnt0", {7'd0, gnt0}, 8'd0);
        checkOutput("reset_gnt1", {7'd0, gnt1}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("release_gnt0", {7'd0, gnt0}, 8'd1);
        checkOutput("release_gnt1", {7'd0, gnt1}, 8'd0);

        // Clean restart for the table.
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            applyStimulus(vecs[i].r0, vecs[i].d0, vecs[i].r1, vecs[i].d1, vecs[i].full, vecs[i].usedw);
            #1;
            checkOutput($sformatf("v%0d_ack0", i), {7'd0, ack0}, {7'd0, vecs[i].a0});
            checkOutput($sformatf("v%0d_ack1", i), {7'd0, ack1}, {7'd0, vecs[i].a1});
            checkOutput($sformatf("v%0d_gnt0", i), {7'd0, gnt0}, {7'd0, vecs[i].g0});
            checkOutput($sformatf("v%0d_gnt1", i), {7'd0, gnt1}, {7'd0, vecs[i].g1});
            checkOutput($sformatf("v%0d_wr_req", i), {7'd0, wr_req}, {7'd0, vecs[i].wreq});
            checkOutput($sformatf("v%0d_wr_data", i), wr_data, vecs[i].wdata);
        end

        // Producer 0 drops, producer 1 takes over and gets one word acked,
        // then reset is pulsed asynchronously in the middle of the cycle.
        @(negedge clk);
        applyStimulus(0, 8'h00, 1, 8'h8A, 0, 8'd0);
        #1;
        checkOutput("pre_gnt0", {7'd0, gnt0}, 8'd1);
        checkOutput("pre_ack0", {7'd0, ack0}, 8'd0);
        checkOutput("pre_wr_data", wr_data, 8'h10);
        @(negedge clk);
        #1;
        checkOutput("mid_gnt1", {7'd0, gnt1}, 8'd1);
        checkOutput("mid_ack1", {7'd0, ack1}, 8'd1);
        @(negedge clk);
        applyStimulus(0, 8'h00, 1, 8'h8B, 0, 8'd0);
        #1;
        checkOutput("mid_wr_req", {7'd0, wr_req}, 8'd1);
        checkOutput("mid_wr_data", wr_data, 8'h8A);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_gnt1", {7'd0, gnt1}, 8'd0);
        checkOutput("async_gnt0", {7'd0, gnt0}, 8'd0);
        checkOutput("async_ack1", {7'd0, ack1}, 8'd0);
        checkOutput("async_wr_req", {7'd0, wr_req}, 8'd0);
        checkOutput("async_wr_data", wr_data, 8'h00);
        applyStimulus(1, 8'h20, 1, 8'h8B, 0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_gnt0", {7'd0, gnt0}, 8'd1);
        checkOutput("post_gnt1", {7'd0, gnt1}, 8'd0);
        checkOutput("post_ack0", {7'd0, ack0}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
